microwave_timer: RTL and testbench
==================================

Name: microwave_timer

Overview:
- Cook-time entry and countdown for the microwave; upstream stage of the per-digit BCD-to-seven-segment decoders.
- Accepts keypad digits as MM:SS, holds the time, counts down once per second while the door is closed and the timer is running, and flags completion.
- Drives four 4-bit BCD digits, one per display decoder, plus status for the magnetron and buzzer logic.

Parameters:
TICK_DIV, 50000000, clk cycles per 1-second countdown step (>=2); benches use 4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
door_closed  in  1  level; 1 = door shut
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  4  keypad value; only 0-9 accepted
start  in  1  one-cycle strobe
stop  in  1  one-cycle strobe
clear  in  1  one-cycle strobe
min_tens  out  4  BCD minutes tens
min_ones  out  4  BCD minutes ones
sec_tens  out  4  BCD seconds tens
sec_ones  out  4  BCD seconds ones
running  out  1  1 while counting (magnetron enable)
done  out  1  level; 1 while in DONE
alarm  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, rst=1):
  - All digits = 0.
  - State = SET.
  - running=0, done=0, alarm=0.
  - Prescaler = 0.
- All outputs are registered.
- States: SET, RUN, PAUSE, DONE.
- Priority within a cycle: clear > stop / door open > start > key_valid > tick.
- SET:
  - key_valid with key_digit<=9 shifts the display left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit. The old min_tens is discarded.
  - key_digit>9 is ignored.
  - clear zeroes all digits.
  - start with door_closed=1 and a nonzero time -> RUN. Otherwise start is ignored.
  - start and key_valid in the same cycle: start is taken, the key is dropped.
- RUN:
  - running=1. Keys are ignored.
  - Prescaler counts 0..TICK_DIV-1. It is held at 0 in every state other than RUN, so the first decrement lands exactly TICK_DIV cycles after entering RUN.
  - At the terminal count the time decrements by one second, with this BCD borrow chain:
    - sec_ones 0 -> 9, borrowing from sec_tens.
    - sec_tens 0 -> 5, borrowing from min_ones.
    - min_ones 0 -> 9, borrowing from min_tens.
  - Entered seconds above 59 (e.g. 1:90) count down literally: 1:90 -> 1:89 ... 1:00 -> 0:59.
  - A decrement that produces 00:00 -> DONE in the same clock edge.
  - stop, or door_closed=0 -> PAUSE. A tick in that same cycle is discarded (no decrement).
  - clear -> SET with all digits zero.
- PAUSE:
  - running=0; digits frozen; keys ignored.
  - start with door_closed=1 -> RUN, prescaler restarts from 0.
  - clear -> SET with all digits zero.
- DONE:
  - done=1, running=0; digits read 00:00.
  - alarm=1 only in the cycle following the entry edge.
  - clear, start, or door_closed=0 -> SET. Digits stay zero.
- The maximum time 99:99 counts down without overflow. Underflow below 00:00 is impossible by construction.
- rst mid-operation aborts immediately to the reset values above.

Decomposition:
- Shared header microwave_defs.vh holds:
  - State encodings (SET=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3).
  - BCD constants BCD_NINE=4'd9 and SEC_TENS_WRAP=4'd5.
  - Reused by the display and control blocks.
- One natural sub-module, tick_gen:
  - Parameterised by TICK_DIV.
  - Inputs: clk, rst, enable.
  - Output: one-cycle tick.
  - Counter is cleared whenever enable=0.

Test Plan (TICK_DIV=4):
1. Keys 1,3,0 in SET -> digits 0,1,3,0. start with door closed -> running=1 next cycle. After 4 cycles -> 0,1,2,9.
2. Load 10:00, run one tick -> 0,9,5,9 (full borrow chain). Load 1:90, one tick -> 0,1,8,9.
3. Load 00:02, start. After 8 cycles -> 00:00, done=1, running=0, alarm high exactly one cycle. clear -> SET, done=0.
4. Running 00:30: drop door_closed on a tick cycle -> PAUSE, digits stay 00:30.
   - start with door open is ignored.
   - Close door + start -> RUN; the next decrement comes 4 cycles later.
5. SET at 00:00: start ignored. key_digit=4'hA ignored. clear and start in the same cycle -> SET, digits 0.
6. Assert rst asynchronously mid-RUN (between edges) -> all digits 0 and running/done/alarm 0 without waiting for clk; after release the block remains in SET.

Source files
------------

// File: rtl/microwave_timer_pkg.sv
// Shared state encodings, BCD constants and the one-second BCD decrement for the microwave timer.
package microwave_timer_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE      = 4'd9;
  localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  // Seconds above 59 are decremented literally; only a zero sec_tens wraps to 5.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = BCD_NINE;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = SEC_TENS_WRAP;
        if (t.min_ones != 4'd0) begin
          r.min_ones = t.min_ones - 4'd1;
        end else begin
          r.min_ones = BCD_NINE;
          r.min_tens = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/microwave_timer_tick_gen.sv
// One-second prescaler: tick is high during the last of every TICK_DIV enabled cycles.
// Counter is forced to 0 whenever enable is low, so each enabled run starts a fresh second.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter is only ever nonzero while counting, so no enable gating is needed here.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/microwave_timer.sv
// Cook-time entry (MM:SS keypad shift-in) and once-per-second BCD countdown with done/alarm status.
// All outputs registered; the prescaler runs only while staying in RUN.
module microwave_timer
  import microwave_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  state_e    state_q, state_d;
  bcd_time_t time_q, time_d, time_dec;
  logic      running_q, done_q, alarm_q;
  logic      tick, tick_en, time_nonzero;

  // Clearing on both the entry and exit edges keeps the first decrement exactly TICK_DIV cycles in.
  assign tick_en = (state_q == ST_RUN) && (state_d == ST_RUN);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (tick_en),
    .tick   (tick)
  );

  assign time_nonzero = (time_q != '0);
  assign time_dec     = bcd_dec(time_q);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    if (clear) begin
      state_d = ST_SET;
      time_d  = '0;
    end else begin
      case (state_q)
        ST_SET: begin
          if (start && door_closed && time_nonzero) begin
            state_d = ST_RUN;
          end else if (key_valid && (key_digit <= BCD_NINE)) begin
            time_d = '{time_q.min_ones, time_q.sec_tens, time_q.sec_ones, key_digit};
          end
        end
        ST_RUN: begin
          if (stop || !door_closed) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            time_d = time_dec;
            if (time_dec == '0) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (!stop && start && door_closed) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start || !door_closed) begin
            state_d = ST_SET;
          end
        end
        default: begin
          state_d = ST_SET;
          time_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SET;
      time_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      alarm_q   <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign min_tens = time_q.min_tens;
  assign min_ones = time_q.min_ones;
  assign sec_tens = time_q.sec_tens;
  assign sec_ones = time_q.sec_ones;
  assign running  = running_q;
  assign done     = done_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed table-driven bench for microwave_timer with TICK_DIV=4, plus an async-reset sequence.
module tb_microwave_timer;

  logic       clk;
  logic       rst;
  logic       door_closed;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, alarm;

  int total;
  int bad;

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sp;
    logic       cl;
    logic       dr;
    logic [15:0] d;
    logic       r;
    logic       dn;
    logic       al;
  } vec_t;

  vec_t vecs[$];

  microwave_timer #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .door_closed (door_closed),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] d, input logic r, input logic dn, input logic al);
    logic [15:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    total++;
    if (got !== d || running !== r || done !== dn || alarm !== al) begin
      bad++;
      $display("FAIL %s: got digits=%h run=%b done=%b alarm=%b, want digits=%h run=%b done=%b alarm=%b",
               nm, got, running, done, alarm, d, r, dn, al);
    end
  endtask

  task automatic add(input logic kv, input logic [3:0] kd, input logic st, input logic sp,
                     input logic cl, input logic dr, input logic [15:0] d,
                     input logic r, input logic dn, input logic al);
    vec_t v;
    v.kv = kv; v.kd = kd; v.st = st; v.sp = sp; v.cl = cl; v.dr = dr;
    v.d = d; v.r = r; v.dn = dn; v.al = al;
    vecs.push_back(v);
  endtask

  task automatic key(input logic [3:0] k, input logic [15:0] d);
    add(1, k, 0, 0, 0, 1, d, 0, 0, 0);
  endtask

  task automatic idle(input int n, input logic [15:0] d, input logic r);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 1, d, r, 0, 0);
  endtask

  task automatic drive_idle();
    key_valid = 0; key_digit = 0; start = 0; stop = 0; clear = 0; door_closed = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    drive_idle();

    // Test 1: entry, start (with a simultaneous key that must be dropped), first tick, stop.
    key(4'd1, 16'h0001);
    key(4'd3, 16'h0013);
    key(4'd0, 16'h0130);
    key(4'hA, 16'h0130);
    add(1, 4'd7, 1, 0, 0, 1, 16'h0130, 1, 0, 0);
    idle(3, 16'h0130, 1);
    idle(1, 16'h0129, 1);
    add(0, 0, 0, 1, 0, 1, 16'h0129, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    // Test 5: start at zero, invalid key, clear+start together, shift discards old min_tens.
    add(0, 0, 1, 0, 0, 1, 16'h0000, 0, 0, 0);
    key(4'hA, 16'h0000);
    key(4'd5, 16'h0005);
    add(0, 0, 1, 0, 1, 1, 16'h0000, 0, 0, 0);
    key(4'd1, 16'h0001);
    key(4'd2, 16'h0012);
    key(4'd3, 16'h0123);
    key(4'd4, 16'h1234);
    key(4'd5, 16'h2345);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    // Test 2: full borrow chain from 10:00, literal countdown of 1:90, and 99:99.
    key(4'd1, 16'h0001); key(4'd0, 16'h0010); key(4'd0, 16'h0100); key(4'd0, 16'h1000);
    add(0, 0, 1, 0, 0, 1, 16'h1000, 1, 0, 0);
    idle(3, 16'h1000, 1);
    idle(1, 16'h0959, 1);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    key(4'd1, 16'h0001); key(4'd9, 16'h0019); key(4'd0, 16'h0190);
    add(0, 0, 1, 0, 0, 1, 16'h0190, 1, 0, 0);
    idle(3, 16'h0190, 1);
    idle(1, 16'h0189, 1);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    key(4'd9, 16'h0009); key(4'd9, 16'h0099); key(4'd9, 16'h0999); key(4'd9, 16'h9999);
    add(0, 0, 1, 0, 0, 1, 16'h9999, 1, 0, 0);
    idle(3, 16'h9999, 1);
    idle(1, 16'h9998, 1);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    // Test 3: 00:02 runs to DONE; alarm for exactly one cycle; clear returns to SET.
    key(4'd2, 16'h0002);
    add(0, 0, 1, 0, 0, 1, 16'h0002, 1, 0, 0);
    idle(3, 16'h0002, 1);
    idle(4, 16'h0001, 1);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    // DONE left by opening the door.
    key(4'd1, 16'h0001);
    add(0, 0, 1, 0, 0, 1, 16'h0001, 1, 0, 0);
    idle(3, 16'h0001, 1);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    idle(1, 16'h0000, 0);
    // Test 4: door opens on a tick cycle; restart timing; stop beats start in PAUSE.
    key(4'd3, 16'h0003); key(4'd0, 16'h0030);
    add(0, 0, 1, 0, 0, 1, 16'h0030, 1, 0, 0);
    idle(3, 16'h0030, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0030, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 16'h0030, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 16'h0030, 1, 0, 0);
    idle(3, 16'h0030, 1);
    idle(1, 16'h0029, 1);
    add(0, 0, 0, 1, 0, 1, 16'h0029, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 16'h0029, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 16'h0029, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);

    repeat (3) step();
    check("reset_state", 16'h0000, 0, 0, 0);
    rst = 0;
    step();
    check("after_release", 16'h0000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      key_valid   = vecs[i].kv;
      key_digit   = vecs[i].kd;
      start       = vecs[i].st;
      stop        = vecs[i].sp;
      clear       = vecs[i].cl;
      door_closed = vecs[i].dr;
      step();
      check($sformatf("vec%0d", i), vecs[i].d, vecs[i].r, vecs[i].dn, vecs[i].al);
    end
    drive_idle();

    // Test 6: asynchronous reset between clock edges while running.
    key_valid = 1; key_digit = 4'd1; step();
    key_digit = 4'd2; step();
    key_valid = 0; start = 1; step();
    start = 0;
    step();
    check("pre_async_rst", 16'h0012, 1, 0, 0);
    #2;
    rst = 1;
    #1;
    check("async_rst_immediate", 16'h0000, 0, 0, 0);
    step();
    rst = 0;
    repeat (5) step();
    check("post_rst_idle", 16'h0000, 0, 0, 0);
    key_valid = 1; key_digit = 4'd7; step();
    key_valid = 0;
    check("post_rst_key", 16'h0007, 0, 0, 0);
    start = 1; step();
    start = 0;
    check("post_rst_start", 16'h0007, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
